dz_scan_driver: RTL and testbench
=================================

// Module: dz_scan_driver
// PURPOSE
//  Downstream display stage of the egg-hatch game: consumes the 4-bit image index and fail flag produced by
//  the dot-matrix transfer stage and drives the 8x8 dual-colour (red/green) LED matrix by row multiplexing.
//  Latches image and colour only at frame boundaries (tear-free), colours by game state, blinks green on fail.
// PARAMETERS
//  SCAN_DIV        1000  clk cycles per row slot (>=2); frame = 8*SCAN_DIV cycles
//  BLINK_FRAMES    32    frames per blink half-period while fail is latched (>=1)
//  ROW_ACTIVE_LOW  1     1: selected row line driven 0, others 1; 0: one-hot high
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous reset, active low
//  num         in   4  image index: 0..7 hatch stages, 8..11 animals, 12..15 blank
//  fail        in   1  game-failed flag, level
//  row         out  8  row select, polarity per ROW_ACTIVE_LOW
//  colr        out  8  red column data, active high, bit i = column i
//  colg        out  8  green column data, active high
//  frame_done  out  1  one-cycle pulse when row 0 of a newly latched frame is presented
// BEHAVIOUR
//  Reset (async, rst_n=0): prescaler=0, row_idx=7, img_q=0, fail_q=0, blink_cnt=0; row=all-inactive
//   (8'hFF if ROW_ACTIVE_LOW else 8'h00), colr=colg=8'h00, frame_done=0. Release mid-frame restarts cleanly.
//  Prescaler counts 0..SCAN_DIV-1, wraps to 0; tick = (prescaler==SCAN_DIV-1).
//  On tick: row_idx <= row_idx+1 (3-bit, 7 wraps to 0). Wrap 7->0 is a frame boundary:
//   img_q<=num, fail_q<=fail, frame_done<=1 for that cycle only; num/fail ignored at all other times.
//  First tick after reset is a frame boundary -> first valid row appears SCAN_DIV cycles after release.
//  All outputs registered and updated on the tick cycle edge together with row_idx (1-clk latency from tick);
//   row and columns never disagree on any cycle.
//  pattern = rom(img_q,row_idx) (8 bits); img_q 12..15 -> 8'h00.
//  Colour select, from latched values:
//   fail_q=1            : colg=pattern & ~{8{blank}}, colr=0
//   fail_q=0, img 0..7  : colr=pattern, colg=0 (red)
//   fail_q=0, img 8..11 : colr=colg=pattern (yellow)
//  Blink: blink_cnt counts frames mod 2*BLINK_FRAMES, increments at each frame boundary while fail_q=1,
//   forced to 0 at a boundary where new fail_q=0. blank=(blink_cnt>=BLINK_FRAMES). Fail from frame 0
//   therefore shows BLINK_FRAMES lit frames first.
//  fail and num changing in same cycle as boundary: values present at that edge are captured.
//  Widths: prescaler sized $clog2(SCAN_DIV); blink_cnt $clog2(2*BLINK_FRAMES); no other arithmetic.
// STRUCTURE
//  dz_pkg: IMG_STAGE_LAST=7, IMG_ANIMAL_FIRST=8, IMG_ANIMAL_LAST=11, ROWS=8, bitmap constants.
//  Sub-module dz_font_rom: combinational (img[3:0], row[2:0]) -> 8-bit pattern, 12 images x 8 rows.
//  Top: prescaler, row counter, frame latch, blink counter, colour mux, output registers.
// TESTING (SCAN_DIV=4, BLINK_FRAMES=2, ROW_ACTIVE_LOW=1)
//  1 Reset: rst_n=0 mid-count -> same cycle row=8'hFF, colr=colg=0; release -> first row=8'hFE at cycle 4
//    with frame_done=1 for exactly 1 cycle, then period 32 cycles.
//  2 Scan: num=3 fail=0 -> row walks FE,FD,FB..7F each 4 cycles; colr==rom(3,r), colg==0 every row.
//  3 Tear-free: change num 3->9 during row 4 -> rows 4..7 still image 3 red; next frame image 9 with
//    colr==colg==rom(9,r).
//  4 Fail blink: fail=1 before boundary, num=9 -> frames 0,1 colg=rom(9,r), colr=0; frames 2,3 colg=0;
//    frame 4 lit again; fail=0 -> blink_cnt=0, colours restored next frame.
//  5 Blank index: num=13 -> colr=colg=0 all rows while row still scans and frame_done pulses.
//  6 Simultaneous: num and fail toggled exactly on boundary edge -> new values captured that frame.

Source files
------------

// File: rtl/dz_pkg.sv
// Shared constants for the egg-hatch LED matrix display stage.
// Image bitmaps are stored row-major: row r occupies bits [8*r +: 8].
package dz_pkg;

    localparam int ROWS      = 8;
    localparam int IMG_COUNT = 12;

    localparam logic [3:0] IMG_STAGE_LAST   = 4'd7;
    localparam logic [3:0] IMG_ANIMAL_FIRST = 4'd8;
    localparam logic [3:0] IMG_ANIMAL_LAST  = 4'd11;

    localparam logic [63:0] BITMAP [IMG_COUNT] = '{
        64'h3C7EFFFFFFFF7E3C,
        64'h3C7EFFF7FFFF7E3C,
        64'h3C7EEFF7FBFF7E3C,
        64'h3C5EEFD7FBDF7E3C,
        64'h3C5AAD57BADA7E3C,
        64'h245A81A5A5815A24,
        64'h18244281A5814224,
        64'h1824423C7E7E3C18,
        64'h6699FF81A5BD8166,
        64'h42E7FFDBFF7E3C24,
        64'h1C3E7F7F3E1C0808,
        64'h81C3E7FFFF7E3C18
    };

    function automatic logic [7:0] row_sel(input logic [2:0] r,
                                           input bit act_low);
        logic [7:0] oh;
        oh = 8'b1 << r;
        return act_low ? ~oh : oh;
    endfunction

endpackage

// File: rtl/dz_font_rom.sv
// Combinational image/row lookup; indices beyond the animal set are blank.
module dz_font_rom
    import dz_pkg::*;
(
    input  logic [3:0] img,
    input  logic [2:0] row,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = '0;
        if (img <= IMG_ANIMAL_LAST)
            pattern = BITMAP[img][{row, 3'b000} +: 8];
    end

endmodule

// File: rtl/dz_scan_driver.sv
// Row-multiplexed driver for the 8x8 red/green matrix with frame-latched,
// tear-free image capture and a green blink while the game is failed.
module dz_scan_driver
    import dz_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_FRAMES   = 32,
    parameter bit ROW_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] num,
    input  logic       fail,
    output logic [7:0] row,
    output logic [7:0] colr,
    output logic [7:0] colg,
    output logic       frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(2 * BLINK_FRAMES);

    localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BL_LAST  = BW'(2 * BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BL_HALF  = BW'(BLINK_FRAMES);
    localparam logic [2:0]    ROW_LAST = 3'(ROWS - 1);
    localparam logic [7:0]    ROW_IDLE = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [PW-1:0] prescaler;
    logic [2:0]    row_idx;
    logic [3:0]    img_q;
    logic          fail_q;
    logic [BW-1:0] blink_cnt;

    logic          tick;
    logic          boundary;
    logic [2:0]    row_n;
    logic [3:0]    img_n;
    logic          fail_n;
    logic [BW-1:0] blink_n;
    logic          blank_n;
    logic [7:0]    pat_n;
    logic [7:0]    colr_n;
    logic [7:0]    colg_n;

    // Pattern is looked up for the row about to be shown, so row and
    // columns load on the same edge.
    dz_font_rom u_rom (
        .img     (img_n),
        .row     (row_n),
        .pattern (pat_n)
    );

    always_comb begin
        tick     = (prescaler == PS_LAST);
        boundary = tick && (row_idx == ROW_LAST);
        row_n    = row_idx + 3'd1;
        img_n    = img_q;
        fail_n   = fail_q;
        blink_n  = blink_cnt;
        if (boundary) begin
            img_n  = num;
            fail_n = fail;
            if (!fail)
                blink_n = '0;
            else if (fail_q)
                blink_n = (blink_cnt == BL_LAST) ? '0 : blink_cnt + BW'(1);
        end
        blank_n = (blink_n >= BL_HALF);

        colr_n = '0;
        colg_n = '0;
        if (fail_n) begin
            colg_n = blank_n ? 8'h00 : pat_n;
        end else if (img_n <= IMG_STAGE_LAST) begin
            colr_n = pat_n;
        end else begin
            colr_n = pat_n;
            colg_n = pat_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            row_idx    <= ROW_LAST;
            img_q      <= '0;
            fail_q     <= 1'b0;
            blink_cnt  <= '0;
            row        <= ROW_IDLE;
            colr       <= '0;
            colg       <= '0;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= tick ? '0 : prescaler + PW'(1);
            frame_done <= boundary;
            if (tick) begin
                row_idx   <= row_n;
                img_q     <= img_n;
                fail_q    <= fail_n;
                blink_cnt <= blink_n;
                row       <= row_sel(row_n, ROW_ACTIVE_LOW);
                colr      <= colr_n;
                colg      <= colg_n;
            end
        end
    end

endmodule

// File: tb/tb_dz_scan_driver.sv
// Randomized bench for dz_scan_driver against a cycle-count based model.
// The model derives slot, row and frame purely from cycles since reset.
module tb_dz_scan_driver;

    localparam int S = 4;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] num;
    logic       fail;
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;
    logic       frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    dz_scan_driver #(
        .SCAN_DIV       (S),
        .BLINK_FRAMES   (B),
        .ROW_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .num        (num),
        .fail       (fail),
        .row        (row),
        .colr       (colr),
        .colg       (colg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [63:0] tbl [12] = '{
        64'h3C7EFFFFFFFF7E3C, 64'h3C7EFFF7FFFF7E3C,
        64'h3C7EEFF7FBFF7E3C, 64'h3C5EEFD7FBDF7E3C,
        64'h3C5AAD57BADA7E3C, 64'h245A81A5A5815A24,
        64'h18244281A5814224, 64'h1824423C7E7E3C18,
        64'h6699FF81A5BD8166, 64'h42E7FFDBFF7E3C24,
        64'h1C3E7F7F3E1C0808, 64'h81C3E7FFFF7E3C18
    };

    function automatic logic [7:0] ref_rom(input int img, input int r);
        logic [63:0] w;
        if (img > 11) return 8'h00;
        w = tbl[img];
        return w[8*r +: 8];
    endfunction

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    int         cyc;
    int         m_img;
    bit         m_fail;
    int         m_run;
    int         m_r;
    logic [7:0] m_pat;
    bit         m_lit;
    logic [7:0] exp_row, exp_r, exp_g;
    logic       exp_fd;

    // Slot t = cyc/S starts at the edge where cyc is a multiple of S;
    // the row shown in slot t is (t+7) mod 8, row 0 opening a frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_img = 0; m_fail = 0; m_run = 0;
            exp_row = 8'hFF; exp_r = 8'h00; exp_g = 8'h00; exp_fd = 1'b0;
        end else begin
            cyc++;
            exp_fd = 1'b0;
            if (cyc % S == 0) begin
                m_r = (cyc / S + 7) % 8;
                if (m_r == 0) begin
                    m_img  = int'(num);
                    m_fail = fail;
                    m_run  = fail ? m_run + 1 : 0;
                    exp_fd = 1'b1;
                end
                m_pat   = ref_rom(m_img, m_r);
                m_lit   = ((m_run - 1) % (2 * B)) < B;
                exp_row = ~(8'd1 << m_r);
                if (m_fail) begin
                    exp_r = 8'h00;
                    exp_g = m_lit ? m_pat : 8'h00;
                end else if (m_img < 8) begin
                    exp_r = m_pat;
                    exp_g = 8'h00;
                end else begin
                    exp_r = m_pat;
                    exp_g = m_pat;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("row", row, exp_row);
        chk("colr", colr, exp_r);
        chk("colg", colg, exp_g);
        chk("frame_done", {7'd0, frame_done}, {7'd0, exp_fd});
    end

    task automatic mid_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_row", row, 8'hFF);
        chk("rst_colr", colr, 8'h00);
        chk("rst_colg", colg, 8'h00);
        chk("rst_fd", {7'd0, frame_done}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        num   = 4'd0;
        fail  = 1'b0;
        hold(3);
        rst_n = 1'b1;

        num = 4'd3;
        hold(50);
        num = 4'd9;
        hold(40);
        fail = 1'b1;
        hold(32 * 6);
        fail = 1'b0;
        hold(64);
        num = 4'd13;
        hold(64);
        hold(2);
        mid_reset();
        num = 4'd5;
        hold(70);

        for (int seg = 0; seg < 80; seg++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < 40 && (cyc % 32) != 3; k++)
                    @(negedge clk);
            end
            num  = 4'($urandom);
            fail = ($urandom_range(0, 2) != 0);
            hold($urandom_range(1, 160));
            if ($urandom_range(0, 9) == 0) begin
                hold($urandom_range(0, 5));
                mid_reset();
            end
        end

        hold(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
